byte_enable_dmem: RTL and testbench

BYTE_ENABLE_DMEM -- requirements
Module: byte_enable_dmem

---
 rtl/byte_enable_dmem.sv | 229 ++++++++++++++++++++++
 tb/tb_byte_enable_dmem.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_enable_dmem.sv
// byte_enable_dmem
//   Word-organised data memory with RISC-V style byte/half/word access.
//   After reset an initialisation sweep writes word i with value i+1, one
//   word per cycle. Once the sweep finishes, the block accepts one load or
//   store per cycle. Each accepted request returns exactly one in-order
//   response READ_LATENCY cycles later. Responses have no backpressure.
//
//   Parameters
//     DEPTH_WORDS  : number of 32-bit words (power of two, 16..65536)
//     READ_LATENCY : response latency in cycles (1..4)
//
//   Ports
//     clk        : clock, rising edge
//     reset      : asynchronous active-high reset
//     req_valid  : request present
//     req_ready  : request can be accepted (READY state only)
//     req_we     : 1 = store, 0 = load
//     req_funct3 : 000 B, 001 H, 010 W, 100 BU, 101 HU
//     req_addr   : byte address
//     req_wdata  : right-aligned store data
//     rsp_valid  : one-cycle response strobe
//     rsp_rdata  : extended load data (0 for stores and errors)
//     rsp_err    : request rejected with no side effect
//     init_done  : initialisation sweep complete
//
//   Build option
//     DMEM_MISALIGN_TRAP_EN : when defined, misaligned H/HU/W accesses are
//     rejected with rsp_err. When undefined, the low address bits are forced
//     to alignment.
module byte_enable_dmem #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_done
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   cnt_r;
  logic            ready_r;

  logic [31:0]     mem_r [DEPTH_WORDS];

  logic [AW-1:0]   word_idx_s;
  logic [1:0]      lane_s;
  logic [31:0]     rd_word_s;
  logic [7:0]      rd_byte_s;
  logic [15:0]     rd_half_s;
  logic            err_s;
  logic [3:0]      be_s;
  logic [31:0]     wdata_s;
  logic [31:0]     load_data_s;
  logic            accept_s;
  logic            wr_en_s;
  logic [31:0]     rsp_data_s;

  logic [READ_LATENCY-1:0] vld_r;
  logic [READ_LATENCY-1:0] err_r;
  logic [31:0]             dat_r [READ_LATENCY];

  assign req_ready  = ready_r;
  assign init_done  = ready_r;
  assign accept_s   = req_valid & ready_r;
  assign word_idx_s = req_addr[AW+1:2];
  assign rd_word_s  = mem_r[word_idx_s];
  assign wr_en_s    = accept_s & req_we & ~err_s;
  assign rsp_data_s = (err_s | req_we) ? 32'h0000_0000 : load_data_s;

  assign rsp_valid  = vld_r[READ_LATENCY-1];
  assign rsp_err    = err_r[READ_LATENCY-1];
  assign rsp_rdata  = dat_r[READ_LATENCY-1];

  // Request decode: error detection, lane selection, store enables, load extraction.
  always_comb begin
    lane_s      = req_addr[1:0];
    err_s       = 1'b0;
    be_s        = 4'b0000;
    wdata_s     = 32'h0000_0000;
    load_data_s = 32'h0000_0000;
    rd_byte_s   = 8'h00;
    rd_half_s   = 16'h0000;

    // Word index above the array (address bits beyond the index field count too).
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end

    case (req_funct3)
      3'b000, 3'b100: begin
        // Byte access; the unsigned variant is load-only.
        if (req_we && req_funct3[2]) begin
          err_s = 1'b1;
        end else begin
          err_s = err_s;
        end
        rd_byte_s   = rd_word_s[{lane_s, 3'b000} +: 8];
        load_data_s = req_funct3[2] ? {24'h00_0000, rd_byte_s}
                                    : {{24{rd_byte_s[7]}}, rd_byte_s};
        be_s        = 4'b0001 << lane_s;
        wdata_s     = {4{req_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        if (lane_s[0]) begin
          err_s = 1'b1;
        end else begin
          err_s = err_s;
        end
`else
        lane_s = {req_addr[1], 1'b0};
`endif
        if (req_we && req_funct3[2]) begin
          err_s = 1'b1;
        end else begin
          err_s = err_s;
        end
        rd_half_s   = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
        load_data_s = req_funct3[2] ? {16'h0000, rd_half_s}
                                    : {{16{rd_half_s[15]}}, rd_half_s};
        be_s        = lane_s[1] ? 4'b1100 : 4'b0011;
        wdata_s     = {2{req_wdata[15:0]}};
      end
      3'b010: begin
`ifdef DMEM_MISALIGN_TRAP_EN
        if (lane_s != 2'b00) begin
          err_s = 1'b1;
        end else begin
          err_s = err_s;
        end
`else
        lane_s = 2'b00;
`endif
        load_data_s = rd_word_s;
        be_s        = 4'b1111;
        wdata_s     = req_wdata;
      end
      default: begin
        err_s = 1'b1;
      end
    endcase
  end

  // Control FSM: initialisation sweep counter, then permanent READY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_IDX) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end else begin
            state_r <= ST_INIT;
            ready_r <= 1'b0;
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_INIT;
          cnt_r   <= '0;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory array: sweep writes during INIT, byte-enabled stores afterwards.
  // The array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[cnt_r] <= 32'(cnt_r) + 32'd1;
    end else if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[word_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures at acceptance, last stage drives the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_r <= '0;
      err_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_r[i] <= 32'h0000_0000;
      end
    end else begin
      vld_r[0] <= accept_s;
      err_r[0] <= accept_s & err_s;
      dat_r[0] <= accept_s ? rsp_data_s : 32'h0000_0000;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        err_r[i] <= err_r[i-1];
        dat_r[i] <= dat_r[i-1];
      end
    end
  end

endmodule

// File: tb/tb_byte_enable_dmem.sv
module tb_byte_enable_dmem;

  localparam int DEPTH = 16;
  localparam int RL    = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  byte_enable_dmem #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endfunction

  function automatic void add(input string nm, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee;
    tbl.push_back(v);
  endfunction

  // Scoreboard monitor: every response must match the oldest expectation on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sbq.size() == 0) begin
        chk32("spurious_rsp_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk32({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        chk32({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk32({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
      end
    end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk32({e.name, "_missing_rsp"}, 32'd0, 32'd1);
    end
  end

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    chk32({v.name, "_ready"}, {31'd0, req_ready}, 32'd1);
    e.name  = v.name;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    e.due   = cyc + RL;
    sbq.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk32("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  // Expects to be called on the negedge where reset was just released.
  task automatic check_init(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!init_done && n < 100);
    chk32(nm, 32'(n), 32'd16);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state with a request presented.
    repeat (3) @(negedge clk);
    chk32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk32("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    chk32("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk32("rst_init_done", {31'd0, init_done}, 32'd0);

    // Release reset; request held valid during the sweep must be ignored.
    reset = 1'b0;
    check_init("init_cycles");
    chk32("ready_after_init", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);

    add("lw_3c",     1'b0, 3'b010, 32'h3C, 32'h0, 32'h0000_0010, 1'b0);
    add("sw_8",      1'b1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0);
    add("sb_9",      1'b1, 3'b000, 32'h09, 32'h0000_007F, 32'h0, 1'b0);
    add("lw_8",      1'b0, 3'b010, 32'h08, 32'h0, 32'hDEAD7FEF, 1'b0);
    add("lb_b",      1'b0, 3'b000, 32'h0B, 32'h0, 32'hFFFF_FFDE, 1'b0);
    add("lbu_b",     1'b0, 3'b100, 32'h0B, 32'h0, 32'h0000_00DE, 1'b0);
    add("lhu_a",     1'b0, 3'b101, 32'h0A, 32'h0, 32'h0000_DEAD, 1'b0);
    add("lh_a",      1'b0, 3'b001, 32'h0A, 32'h0, 32'hFFFF_DEAD, 1'b0);
    add("lh_8",      1'b0, 3'b001, 32'h08, 32'h0, 32'h0000_7FEF, 1'b0);
    add("lb_8",      1'b0, 3'b000, 32'h08, 32'h0, 32'hFFFF_FFEF, 1'b0);
    add("sw_oor",    1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0, 1'b1);
    add("s_f3_111",  1'b1, 3'b111, 32'h00, 32'hFFFF_FFFF, 32'h0, 1'b1);
    add("lw_0",      1'b0, 3'b010, 32'h00, 32'h0, 32'h0000_0001, 1'b0);
    add("l_f3_011",  1'b0, 3'b011, 32'h04, 32'h0, 32'h0, 1'b1);
    add("sbu_4",     1'b1, 3'b100, 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b1);
    add("lw_4",      1'b0, 3'b010, 32'h04, 32'h0, 32'h0000_0002, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add("lw_6_mis",  1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1);
`else
    add("lw_6_mis",  1'b0, 3'b010, 32'h06, 32'h0, 32'h0000_0002, 1'b0);
`endif
    add("sh_e",      1'b1, 3'b001, 32'h0E, 32'hAAAA5555, 32'h0, 1'b0);
    add("lw_c",      1'b0, 3'b010, 32'h0C, 32'h0, 32'h5555_0004, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add("lh_f_mis",  1'b0, 3'b001, 32'h0F, 32'h0, 32'h0, 1'b1);
    add("sh_5_mis",  1'b1, 3'b001, 32'h05, 32'h0000_BEEF, 32'h0, 1'b1);
    add("lw_4b",     1'b0, 3'b010, 32'h04, 32'h0, 32'h0000_0002, 1'b0);
`else
    add("lh_f_mis",  1'b0, 3'b001, 32'h0F, 32'h0, 32'h0000_5555, 1'b0);
    add("sh_5_mis",  1'b1, 3'b001, 32'h05, 32'h0000_BEEF, 32'h0, 1'b0);
    add("lw_4b",     1'b0, 3'b010, 32'h04, 32'h0, 32'h0000_BEEF, 1'b0);
`endif
    add("lw_hi",     1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
    add("l_f3_110",  1'b0, 3'b110, 32'h00, 32'h0, 32'h0, 1'b1);
    add("sb_3f",     1'b1, 3'b000, 32'h3F, 32'h0000_0080, 32'h0, 1'b0);
    add("lb_3f",     1'b0, 3'b000, 32'h3F, 32'h0, 32'hFFFF_FF80, 1'b0);
    add("lw_3c_b",   1'b0, 3'b010, 32'h3C, 32'h0, 32'h8000_0010, 1'b0);

    // Back-to-back stream: one request per cycle.
    foreach (tbl[i]) drive(tbl[i]);
    idle();
    drain();

    // Gapped requests: latency must hold with idle cycles between.
    v.we = 1'b0; v.f3 = 3'b010; v.wdata = 32'h0;
    v.name = "gap_lw_8"; v.addr = 32'h08; v.exp_rdata = 32'hDEAD7FEF; v.exp_err = 1'b0;
    drive(v);
    idle();
    idle();
    v.name = "gap_lw_c"; v.addr = 32'h0C; v.exp_rdata = 32'h5555_0004;
    drive(v);
    idle();
    drain();

    // Reset with two responses in flight: both discarded, sweep restarts.
    v.name = "fl_a"; v.addr = 32'h00; v.exp_rdata = 32'h1;
    drive(v);
    v.name = "fl_b"; v.addr = 32'h04;
    drive(v);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    chk32("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk32("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_init("reinit_cycles");
    idle();
    v.name = "post_lw_3c"; v.addr = 32'h3C; v.exp_rdata = 32'h0000_0010;
    drive(v);
    v.name = "post_lw_8"; v.addr = 32'h08; v.exp_rdata = 32'h0000_0003;
    drive(v);
    idle();
    drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
